team_gpio_wb_ctrl: RTL and testbench
====================================

TEAM_GPIO_WB_CTRL -- requirements
Module: team_gpio_wb_ctrl

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 38, meaning number of pad pins handled (legal range 1..64).
REQ-002 SHALL have parameter RSVD_MASK, default 64'h1E, meaning a 1 marks a pin reserved (forced input); the default reserves pins 4:1.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the 256-byte-aligned register window base.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-006 wb_rst_i  in  1  synchronous active-high reset.
REQ-007 wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-008 wbs_sel_i  in  4  byte lane enables; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-009 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-010 gpio_in  in  NUM_GPIO  raw asynchronous pad inputs.
REQ-011 gpio_out  out  NUM_GPIO  pad output values; gpio_oeb  out  NUM_GPIO  active-low output enable.
REQ-012 irq_o  out  1  level interrupt request.

Function
REQ-013 SHALL decode a hit when cyc&stb and wbs_adr_i[31:8]==BASE_ADDR[31:8]; offsets use adr[7:2].
REQ-014 Each register SHALL span two words: low word = pins 31:0, high word (+4) = pins 63:32.
REQ-015 Map: OUT 0x00, OE 0x08 (1 = drive), IN 0x10 (RO), RISE_EN 0x18, FALL_EN 0x20, STATUS 0x28 (write-1-to-clear).
REQ-016 wbs_ack_o SHALL assert the cycle after a hit with ack low, for exactly one cycle; a strobe held across consecutive cycles yields ack every second cycle.
REQ-017 Writes SHALL take effect on the ack edge, per byte lane enabled by wbs_sel_i; disabled lanes are unchanged.
REQ-018 wbs_dat_o SHALL be registered, valid while ack high, and 0 whenever ack is low.
REQ-019 Unmapped offsets inside the window SHALL ack, read 0, and ignore writes; out-of-window addresses SHALL never ack.
REQ-020 Bits for reserved pins and pins >= NUM_GPIO SHALL read 0 in every register and ignore writes.
REQ-021 gpio_out = OUT & ~RSVD; gpio_oeb = ~(OE & ~RSVD); reserved pins SHALL always have gpio_oeb=1, gpio_out=0.
REQ-022 gpio_in SHALL pass a 2-flop synchronizer; IN reads the second stage; a pad change is visible in IN 2 cycles later.
REQ-023 A third flop SHALL hold the prior synchronized value; a rising edge (prev 0, now 1) with RISE_EN set, or a falling edge with FALL_EN set, SHALL set the STATUS bit next cycle.
REQ-024 Edge detection SHALL apply to all non-reserved pins regardless of OE.
REQ-025 If a W1C and an edge set hit the same STATUS bit in the same cycle, set SHALL win.
REQ-026 irq_o SHALL be the registered OR of all STATUS bits (1 cycle after STATUS changes).
REQ-027 Clearing an enable SHALL NOT clear already-set STATUS bits.

Reset
REQ-028 On wb_rst_i high at a clock edge: OUT, OE, RISE_EN, FALL_EN, STATUS, synchronizer and previous-value flops SHALL go to 0; wbs_ack_o=0, wbs_dat_o=0, irq_o=0, gpio_out=0, gpio_oeb=all 1.
REQ-029 Reset during an open Wishbone cycle SHALL abort it with no ack and no register update; the master re-issues.
REQ-030 The first post-reset edges SHALL NOT set STATUS, because all enables are 0.

Verification
REQ-031 Write 0xFFFF_FFFF sel=4'hF to 0x00 and 0x08 -> gpio_out[31:0]=0xFFFF_FFE1, gpio_oeb[31:0]=0x0000_001E; readback 0x00 = 0xFFFF_FFE1; ack is a single pulse one cycle after stb.
REQ-032 Write 0x0000_00AA sel=4'b0001 to 0x04 after OUT-high=0x3F -> reads 0x2A (NUM_GPIO=38 masks bits 7:6 off).
REQ-033 Set RISE_EN bit 5 and drive gpio_in[5] 0->1 -> STATUS bit5 set 3 cycles later, irq_o high 1 cycle after that; W1C 0x20 to 0x28 -> irq_o low.
REQ-034 Drive a gpio_in[5] edge in the same cycle a W1C of bit 5 is acked -> STATUS bit5 remains 1.
REQ-035 Read 0x3C and 0x100+BASE_ADDR -> 0x3C acks with data 0; the out-of-window access never acks.
REQ-036 Assert wb_rst_i mid-write with stb held -> no ack, all registers 0, gpio_oeb all 1.

Source files
------------

// File: rtl/team_gpio_wb_ctrl.sv
// Wishbone-mapped GPIO block: output/enable registers, synchronized inputs,
// per-pin rise/fall edge capture into a W1C status register with a level IRQ.
module team_gpio_wb_ctrl #(
    parameter int          NUM_GPIO  = 38,
    parameter logic [63:0] RSVD_MASK = 64'h1E,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq_o
);

    localparam logic [63:0] PIN_MASK  = (NUM_GPIO >= 64) ? {64{1'b1}}
                                                         : ((64'd1 << NUM_GPIO) - 64'd1);
    localparam logic [63:0] LIVE_MASK = PIN_MASK & ~RSVD_MASK;

    localparam logic [4:0] REG_OUT    = 5'd0;
    localparam logic [4:0] REG_OE     = 5'd1;
    localparam logic [4:0] REG_IN     = 5'd2;
    localparam logic [4:0] REG_RISE   = 5'd3;
    localparam logic [4:0] REG_FALL   = 5'd4;
    localparam logic [4:0] REG_STATUS = 5'd5;

    logic [63:0] out_q, out_d, oe_q, oe_d;
    logic [63:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [63:0] status_q, status_d;
    logic [63:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic        ack_q, ack_d, irq_q, irq_d;
    logic [31:0] dat_q, dat_d;

    logic [63:0] gpio_in_ext, lane_mask, wdata64, rd_reg, edge_set, w1c_mask;
    logic [31:0] lane32;
    logic [4:0]  reg_idx;
    logic        hit, start, wr, upper;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    function automatic logic [63:0] merge(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [63:0] mask);
        merge = ((old_val & ~mask) | (new_val & mask)) & LIVE_MASK;
    endfunction

    always_comb begin
        gpio_in_ext = '0;
        gpio_in_ext[NUM_GPIO-1:0] = gpio_in;

        hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        start   = hit & ~ack_q;
        wr      = start & wbs_we_i;
        reg_idx = wbs_adr_i[7:3];
        upper   = wbs_adr_i[2];

        lane32    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        lane_mask = upper ? {lane32, 32'h0} : {32'h0, lane32};
        wdata64   = {wbs_dat_i, wbs_dat_i};

        case (reg_idx)
            REG_OUT:    rd_reg = out_q;
            REG_OE:     rd_reg = oe_q;
            REG_IN:     rd_reg = sync2_q & LIVE_MASK;
            REG_RISE:   rd_reg = rise_en_q;
            REG_FALL:   rd_reg = fall_en_q;
            REG_STATUS: rd_reg = status_q;
            default:    rd_reg = '0;
        endcase

        out_d     = (wr && reg_idx == REG_OUT)  ? merge(out_q, wdata64, lane_mask)     : out_q;
        oe_d      = (wr && reg_idx == REG_OE)   ? merge(oe_q, wdata64, lane_mask)      : oe_q;
        rise_en_d = (wr && reg_idx == REG_RISE) ? merge(rise_en_q, wdata64, lane_mask) : rise_en_q;
        fall_en_d = (wr && reg_idx == REG_FALL) ? merge(fall_en_q, wdata64, lane_mask) : fall_en_q;

        // An edge landing in the same cycle as a clear keeps the bit set.
        edge_set = ((sync2_q & ~prev_q & rise_en_q) | (~sync2_q & prev_q & fall_en_q)) & LIVE_MASK;
        w1c_mask = (wr && reg_idx == REG_STATUS) ? (wdata64 & lane_mask) : '0;
        status_d = ((status_q & ~w1c_mask) | edge_set) & LIVE_MASK;

        sync1_d = gpio_in_ext & LIVE_MASK;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        irq_d = |status_q;
        ack_d = start;
        dat_d = start ? (upper ? rd_reg[63:32] : rd_reg[31:0]) : 32'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign gpio_out  = out_q[NUM_GPIO-1:0];
    assign gpio_oeb  = ~oe_q[NUM_GPIO-1:0];

endmodule

// File: tb/tb_team_gpio_wb_ctrl.sv
// Directed bench for team_gpio_wb_ctrl: bus reads are scored by a monitor that
// pops expected data on every ack; pin and irq levels are checked in-line.
module tb_team_gpio_wb_ctrl;

    localparam int          NUM_GPIO = 38;
    localparam logic [31:0] BASE     = 32'h3000_0000;

    typedef struct packed {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                cyc, stb, we;
    logic [3:0]          sel;
    logic [31:0]         adr, wdat;
    logic                ack;
    logic [31:0]         rdat;
    logic [NUM_GPIO-1:0] gpio_in, gpio_out, gpio_oeb;
    logic                irq;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    team_gpio_wb_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // Monitor: every ack must match a queued transaction; reads compare data.
    always @(negedge clk) begin
        if (ack) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL stray_ack adr=%h got ack=1 required ack=0", adr);
            end else begin
                e = exp_q.pop_front();
                if (e.is_read) begin
                    checks++;
                    if (rdat !== e.data) begin
                        errors++;
                        $display("[TB] FAIL rd_data adr=%h got=%h required=%h", adr, rdat, e.data);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [31:0] exp_rd,
                                 input bit in_window);
        int  cycles = 0;
        bit  got = 0;
        if (in_window) exp_q.push_back('{is_read: !w, data: exp_rd});
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (ack) begin
                got = 1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (in_window) begin
            if (!got) begin
                checks++;
                errors++;
                $display("[TB] FAIL ack_timeout adr=%h got no ack required ack", a);
                void'(exp_q.pop_back());
            end else begin
                checkOutput("ack_latency", 64'(cycles), 64'd1);
            end
            @(posedge clk); #1;
            checkOutput("ack_single_pulse", 64'(ack), 64'd0);
        end else begin
            checkOutput("oow_no_ack", 64'(got), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; wdat = '0; gpio_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ack", 64'(ack), 64'd0);
        checkOutput("rst_dat", 64'(rdat), 64'd0);
        checkOutput("rst_irq", 64'(irq), 64'd0);
        checkOutput("rst_gpio_out", 64'(gpio_out), 64'd0);
        checkOutput("rst_gpio_oeb", 64'(gpio_oeb), 64'h3F_FFFF_FFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full writes to OUT/OE low words; reserved pins 4:1 stay input
        applyStimulus(1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        applyStimulus(1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        checkOutput("gpio_out_lo", 64'(gpio_out[31:0]), 64'hFFFF_FFE1);
        checkOutput("gpio_oeb_lo", 64'(gpio_oeb[31:0]), 64'h0000_001E);
        applyStimulus(0, BASE + 32'h00, 32'h0, 4'h0, 32'hFFFF_FFE1, 1);

        // High word masking and byte lanes
        applyStimulus(1, BASE + 32'h04, 32'h0000_003F, 4'hF, 32'h0, 1);
        applyStimulus(0, BASE + 32'h04, 32'h0, 4'h0, 32'h0000_003F, 1);
        applyStimulus(1, BASE + 32'h04, 32'h0000_00AA, 4'b0001, 32'h0, 1);
        applyStimulus(0, BASE + 32'h04, 32'h0, 4'h0, 32'h0000_002A, 1);
        checkOutput("gpio_out_hi", 64'(gpio_out[37:32]), 64'h2A);
        applyStimulus(1, BASE + 32'h20, 32'h1234_5678, 4'b1010, 32'h0, 1);
        applyStimulus(0, BASE + 32'h20, 32'h0, 4'h0, 32'h1200_5600, 1);
        applyStimulus(1, BASE + 32'h20, 32'h0, 4'hF, 32'h0, 1);

        // Input path through the synchronizer
        gpio_in = 38'h2A_0000_00FF;
        repeat (3) begin @(posedge clk); #1; end
        applyStimulus(0, BASE + 32'h10, 32'h0, 4'h0, 32'h0000_00E1, 1);
        applyStimulus(0, BASE + 32'h14, 32'h0, 4'h0, 32'h0000_002A, 1);
        gpio_in = '0;
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("irq_no_enable", 64'(irq), 64'd0);

        // Rising edge on pin 5 -> status three edges later, irq one after
        applyStimulus(1, BASE + 32'h18, 32'h0000_0020, 4'hF, 32'h0, 1);
        gpio_in[5] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("irq_before", 64'(irq), 64'd0);
        @(posedge clk); #1;
        checkOutput("irq_after_rise", 64'(irq), 64'd1);
        applyStimulus(1, BASE + 32'h18, 32'h0, 4'hF, 32'h0, 1);
        applyStimulus(0, BASE + 32'h28, 32'h0, 4'h0, 32'h0000_0020, 1);

        // Falling edge arriving on the same edge as the W1C ack: set wins
        applyStimulus(1, BASE + 32'h20, 32'h0000_0020, 4'hF, 32'h0, 1);
        gpio_in[5] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        applyStimulus(1, BASE + 32'h28, 32'h0000_0020, 4'hF, 32'h0, 1);
        applyStimulus(0, BASE + 32'h28, 32'h0, 4'h0, 32'h0000_0020, 1);
        checkOutput("irq_set_wins", 64'(irq), 64'd1);
        applyStimulus(1, BASE + 32'h20, 32'h0, 4'hF, 32'h0, 1);
        applyStimulus(1, BASE + 32'h28, 32'h0000_0020, 4'hF, 32'h0, 1);
        applyStimulus(0, BASE + 32'h28, 32'h0, 4'h0, 32'h0, 1);
        checkOutput("irq_cleared", 64'(irq), 64'd0);

        // Unmapped in-window offsets and an out-of-window access
        applyStimulus(0, BASE + 32'h3C, 32'h0, 4'h0, 32'h0, 1);
        applyStimulus(1, BASE + 32'h30, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
        applyStimulus(0, BASE + 32'h30, 32'h0, 4'h0, 32'h0, 1);
        applyStimulus(0, BASE + 32'h100, 32'h0, 4'h0, 32'h0, 0);

        // Reset lands on an open write cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        adr = BASE + 32'h08; wdat = 32'h5555_5555; rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("rst_mid_no_ack", 64'(ack), 64'd0);
        end
        checkOutput("rst_mid_gpio_out", 64'(gpio_out), 64'd0);
        checkOutput("rst_mid_gpio_oeb", 64'(gpio_oeb), 64'h3F_FFFF_FFFF);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, BASE + 32'h00, 32'h0, 4'h0, 32'h0, 1);
        applyStimulus(0, BASE + 32'h08, 32'h0, 4'h0, 32'h0, 1);
        applyStimulus(0, BASE + 32'h0C, 32'h0, 4'h0, 32'h0, 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
